l1_cache_responder: RTL and testbench
=====================================

Name: l1_cache_responder

Overview:
- Responder end of the core load/store cache interface: accepts single-cycle `req_valid` requests from the load and store units.
- Answers with a same-cycle `hit`; on a miss it answers later with a one-cycle `gnt` pulse.
- Direct-mapped, one byte per line, write-through cache with a 1-entry posted write buffer.
- Sits between a core's load/store units and the shared memory bus.

Parameters:
- ADDR_W, 12, request/memory address width.
- DATA_W, 8, data width (one byte per line).
- INDEX_W, 4, index bits; 2**INDEX_W lines; tag = ADDR_W-INDEX_W bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset (synchronous, active-high).
- req_valid  input  1  request strobe, one cycle per request.
- req_we  input  1  1=store, 0=load; sampled with req_valid.
- req_addr  input  ADDR_W  request address; sampled with req_valid.
- req_wdata  input  DATA_W  store data; sampled with req_valid.
- hit  output  1  combinational; request completes this cycle.
- gnt  output  1  one-cycle pulse; a missed request has completed.
- rdata  output  DATA_W  load data, registered.
- busy  output  1  high in any state other than IDLE.
- mem_req  output  1  memory bus request, held until mem_ack.
- mem_we  output  1  memory write.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ack  input  1  memory completion; mem_rdata valid this cycle.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset: all line valid bits cleared, write buffer empty, state IDLE. Outputs: hit=0, gnt=0, rdata=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Request acceptance: only in IDLE. A req_valid in any other state is ignored; protocol allows one outstanding request.
- Lookup: line = valid[idx] && tag[idx]==req_addr tag.

Load, in IDLE:
- If line matches: hit=1 the same cycle as req_valid; rdata<=data[idx] next edge.
- Else: hit=0 and the request is latched.
  - If the write buffer is full, go to DRAIN, then MISS_RD.
  - Otherwise go directly to MISS_RD.

Store, in IDLE:
- If line matches and the write buffer is empty: hit=1; update data[idx]; load the write buffer with {addr,wdata}.
- Otherwise: hit=0 and the request is latched.
  - If the buffer is full, go to DRAIN, then ST_WR.
  - Otherwise go directly to ST_WR.
- Store miss does not allocate a line.

States:
- DRAIN: mem_req=1, mem_we=1, buffer contents on mem_addr/mem_wdata. On mem_ack, clear buffer and go to MISS_RD or ST_WR.
- MISS_RD: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack: fill valid/tag/data[idx], rdata<=mem_rdata, go to RESP.
- ST_WR: mem_req=1, mem_we=1, latched addr/data. On mem_ack: if the line matches, update data[idx]; go to RESP.
- RESP: gnt=1 for exactly one cycle; next state IDLE.

Background drain and ordering:
- In IDLE with the buffer full and no req_valid this cycle, the buffer drains (mem_req=1, mem_we=1) without leaving IDLE.
- A req_valid arriving while this drain is in flight: mem_req stays asserted with the buffer contents; the request is latched and handled via DRAIN.
- A store hit (which writes the buffer) cannot occur while the buffer is full, so no buffered write is lost.
- Read-after-write ordering: every miss drains the buffer before its memory read.

Memory bus:
- mem_req/mem_we/mem_addr/mem_wdata are stable from assertion until mem_ack.
- They are 0 when idle.
- mem_ack without mem_req is ignored.

rdata:
- Holds its value until the next load completes.
- The requester samples rdata in the cycle after hit, or in the cycle after gnt.

Latency:
- Hit: 0 cycles (hit with valid); data one edge later.
- Miss: gnt one cycle after the final mem_ack.

Reset mid-operation: abandons the miss, no gnt, mem_req drops; the buffered write is discarded.

Optional Feature:
- Macro: CACHE_STATS_EN.
- When defined:
  - Adds output ports hit_count [15:0] and miss_count [15:0].
  - Each increments by 1 on every accepted request classified as hit or miss.
  - Saturating at 16'hFFFF; reset to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold load: after reset, load addr 12'h0A5; memory returns 8'h3C after 3 cycles → hit=0, one mem read of 12'h0A5, gnt one cycle after mem_ack, rdata=8'h3C.
- Repeat load hit: load 12'h0A5 again → hit=1 the same cycle, no mem_req, rdata=8'h3C next cycle.
- Store hit: store 8'h77 to 12'h0A5 → hit=1; background mem write 12'h0A5/8'h77; a following load 12'h0A5 hits with rdata=8'h77.
- Store miss, buffer full: store 12'h0A5 hit, then immediately store 8'h11 to 12'h1B3 → DRAIN write 12'h0A5 first, then write 12'h1B3/8'h11, gnt; a load of 12'h1B3 then misses (no allocate).
- Conflict eviction: load 12'h005, then 12'h105 (same index, different tag) → both miss; a third load of 12'h005 misses again.
- Reset in MISS_RD: assert rst while waiting for mem_ack → mem_req=0 next cycle, no gnt, a later load of the same address misses; with CACHE_STATS_EN, the counters read 0 after reset.

Source files
------------

// File: rtl/l1_cache_responder_if.sv
// Core-side request/response and memory-bus signals of the L1 cache responder.
// The slave modport is the cache; the master modport is the core plus memory environment.
interface l1_cache_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              hit;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output hit, gnt, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  hit, gnt, rdata, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_cache_responder.sv
// Direct-mapped, byte-per-line, write-through L1 responder with a 1-entry posted write buffer.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module l1_cache_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  l1_cache_responder_if.slave    bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {IDLE, DRAIN, MISS_RD, ST_WR, RESP} state_t;

  state_t state_reg, state_next;

  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic              wb_full_reg;
  logic [ADDR_W-1:0] wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;

  logic              lat_we_reg;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic [DATA_W-1:0] lat_data_reg;

  logic [DATA_W-1:0] rdata_reg;

  logic [INDEX_W-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;
  logic               req_match, lat_match;
  logic               accept, hit_now, drain_done;

  logic              mem_req_next, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;

  assign req_idx   = bus.req_addr[INDEX_W-1:0];
  assign req_tag   = bus.req_addr[ADDR_W-1:INDEX_W];
  assign lat_idx   = lat_addr_reg[INDEX_W-1:0];
  assign lat_tag   = lat_addr_reg[ADDR_W-1:INDEX_W];
  assign req_match = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign lat_match = valid_reg[lat_idx] && (tag_mem[lat_idx] == lat_tag);

  assign accept  = !rst && (state_reg == IDLE) && bus.req_valid;
  // A store may only hit when the buffer is free to take its posted write.
  assign hit_now = accept && req_match && (!bus.req_we || !wb_full_reg);

  // The buffered write completes in IDLE (background) or in DRAIN.
  assign drain_done = wb_full_reg && bus.mem_ack &&
                      ((state_reg == IDLE) || (state_reg == DRAIN));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && !hit_now) begin
          if (wb_full_reg && !bus.mem_ack)
            state_next = DRAIN;
          else
            state_next = bus.req_we ? ST_WR : MISS_RD;
        end
      end
      DRAIN:   if (bus.mem_ack) state_next = lat_we_reg ? ST_WR : MISS_RD;
      MISS_RD: if (bus.mem_ack) state_next = RESP;
      ST_WR:   if (bus.mem_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_next   = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    case (state_reg)
      IDLE, DRAIN: begin
        if (wb_full_reg) begin
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = wb_addr_reg;
          mem_wdata_next = wb_data_reg;
        end
      end
      MISS_RD: begin
        mem_req_next  = 1'b1;
        mem_addr_next = lat_addr_reg;
      end
      ST_WR: begin
        mem_req_next   = 1'b1;
        mem_we_next    = 1'b1;
        mem_addr_next  = lat_addr_reg;
        mem_wdata_next = lat_data_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      wb_full_reg  <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      lat_we_reg   <= 1'b0;
      lat_addr_reg <= '0;
      lat_data_reg <= '0;
      rdata_reg    <= '0;
    end else begin
      if (drain_done)
        wb_full_reg <= 1'b0;
      if (hit_now && bus.req_we) begin
        wb_full_reg <= 1'b1;
        wb_addr_reg <= bus.req_addr;
        wb_data_reg <= bus.req_wdata;
      end
      if (accept && !hit_now) begin
        lat_we_reg   <= bus.req_we;
        lat_addr_reg <= bus.req_addr;
        lat_data_reg <= bus.req_wdata;
      end
      if (hit_now && !bus.req_we)
        rdata_reg <= data_mem[req_idx];
      if ((state_reg == MISS_RD) && bus.mem_ack) begin
        valid_reg[lat_idx] <= 1'b1;
        rdata_reg          <= bus.mem_rdata;
      end
    end
  end

  // Tag/data storage carries no reset; valid_reg alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (hit_now && bus.req_we) begin
      data_mem[req_idx] <= bus.req_wdata;
    end else if (!rst && (state_reg == MISS_RD) && bus.mem_ack) begin
      tag_mem[lat_idx]  <= lat_tag;
      data_mem[lat_idx] <= bus.mem_rdata;
    end else if (!rst && (state_reg == ST_WR) && bus.mem_ack && lat_match) begin
      data_mem[lat_idx] <= lat_data_reg;
    end
  end

  assign bus.hit       = hit_now;
  assign bus.gnt       = (state_reg == RESP);
  assign bus.rdata     = rdata_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.mem_req   = mem_req_next;
  assign bus.mem_we    = mem_we_next;
  assign bus.mem_addr  = mem_addr_next;
  assign bus.mem_wdata = mem_wdata_next;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_reg, miss_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (accept) begin
      if (hit_now) begin
        if (hit_count_reg != 16'hFFFF) hit_count_reg <= hit_count_reg + 16'd1;
      end else begin
        if (miss_count_reg != 16'hFFFF) miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif
endmodule

// File: tb/tb_l1_cache_responder.sv
// Randomised/directed bench for l1_cache_responder against a flat-memory plus cache-tag model.
module tb_l1_cache_responder;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 8;
  localparam int INDEX_W = 4;
  localparam int LINES   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_cache_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  l1_cache_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int memreq_cycles = 0;

  logic [7:0] backing [4096];   // memory behind the bus
  logic [7:0] ref_mem [4096];   // architectural memory in program order
  bit         m_valid [LINES];
  logic [7:0] m_tag   [LINES];
  bit         tb_wb_full = 0;
  wr_t        exp_wq[$];
  logic [11:0] exp_rq[$];

  int fixed_delay = -1;
  bit hold = 0;
  int reads_seen = 0;
  int writes_seen = 0;
  int last_ack_cyc = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req === 1'b1) memreq_cycles <= memreq_cycles + 1;
  end

  // Memory model: acks after a per-transaction delay and checks bus ordering/stability.
  initial begin : responder
    int cnt;
    int dly;
    logic [11:0] h_addr;
    logic        h_we;
    logic [7:0]  h_data;
    wr_t         e;
    cnt = 0; dly = 0;
    h_addr = '0; h_we = 0; h_data = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
        if (h_we) begin
          writes_seen++;
          backing[h_addr] = h_data;
          if (tb_wb_full) tb_wb_full = 0;
          n_checks++;
          if (exp_wq.size() == 0) begin
            n_fail++;
            $display("FAIL mem_write unexpected: got %h/%h, required none", h_addr, h_data);
          end else begin
            e = exp_wq.pop_front();
            if (h_addr !== e.a || h_data !== e.d) begin
              n_fail++;
              $display("FAIL mem_write order: got %h/%h, required %h/%h", h_addr, h_data, e.a, e.d);
            end
          end
        end else begin
          reads_seen++;
          n_checks++;
          if (exp_rq.size() == 0 || h_addr !== exp_rq[0] || exp_wq.size() != 0) begin
            n_fail++;
            $display("FAIL mem_read: got %h (pending writes %0d), required %h with no pending writes",
                     h_addr, exp_wq.size(), (exp_rq.size() != 0) ? exp_rq[0] : 12'h000);
          end
          if (exp_rq.size() != 0) void'(exp_rq.pop_front());
        end
        continue;
      end
      if (rst || bus.mem_req !== 1'b1) begin
        cnt = 0;
        continue;
      end
      if (cnt == 0) begin
        h_addr = bus.mem_addr; h_we = bus.mem_we; h_data = bus.mem_wdata;
        dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end else begin
        n_checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {h_we, h_addr, h_data}) begin
          n_fail++;
          $display("FAIL mem_stable: got %b/%h/%h, required %b/%h/%h",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata, h_we, h_addr, h_data);
        end
      end
      if (!hold && cnt >= dly) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = backing[h_addr];
        last_ack_cyc  = cyc;
      end else begin
        cnt++;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    tb_wb_full = 0;
    exp_wq.delete();
    exp_rq.delete();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One request; assumes entry at posedge+2 and returns at posedge+2.
  task automatic do_req(input bit we, input logic [11:0] addr, input logic [7:0] wdata);
    int idx;
    int waitc;
    bit exp_hit;
    bit got;
    logic [7:0] exp_rd;
    idx = int'(addr[3:0]);
    waitc = 0;
    while (bus.busy !== 1'b0 && waitc < 100) begin @(posedge clk); #2; waitc++; end
    if (bus.busy !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL idle_wait: busy=%b, required 0", bus.busy);
      return;
    end
    exp_hit = m_valid[idx] && (m_tag[idx] == addr[11:4]) && (!we || !tb_wb_full);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    n_checks++;
    if (bus.hit !== exp_hit) begin
      n_fail++;
      $display("FAIL hit %s %h: got %b, required %b", we ? "ST" : "LD", addr, bus.hit, exp_hit);
    end
    if (we) ref_mem[addr] = wdata;
    exp_rd = ref_mem[addr];
    if (exp_hit) begin
      exp_hits++;
      if (we) begin tb_wb_full = 1; exp_wq.push_back('{a: addr, d: wdata}); end
    end else begin
      exp_misses++;
      if (we) exp_wq.push_back('{a: addr, d: wdata});
      else    exp_rq.push_back(addr);
    end
    @(posedge clk); #2;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    if (!exp_hit) begin
      got = 0; waitc = 0;
      while (!got && waitc < 100) begin
        @(negedge clk);
        if (bus.gnt === 1'b1) got = 1; else waitc++;
      end
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL gnt_timeout %h: got no gnt, required gnt", addr);
      end else if (cyc != last_ack_cyc + 1) begin
        n_fail++;
        $display("FAIL gnt_latency %h: got cycle %0d, required %0d", addr, cyc, last_ack_cyc + 1);
      end
      @(posedge clk); #2;
      if (!we) begin m_valid[idx] = 1; m_tag[idx] = addr[11:4]; end
    end
    if (!we) begin
      n_checks++;
      if (bus.rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rdata %h: got %h, required %h", addr, bus.rdata, exp_rd);
      end
    end
    $display("txn %s addr=%h wdata=%h exp_hit=%0d rdata=%h", we ? "ST" : "LD", addr, wdata, exp_hit, bus.rdata);
  endtask

  task automatic wait_wb_empty();
    int w = 0;
    while ((tb_wb_full || bus.mem_req === 1'b1) && w < 100) begin @(posedge clk); #2; w++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_checks += 8;
    if (bus.hit !== 1'b0)      begin n_fail++; $display("FAIL reset_hit: got %b, required 0", bus.hit); end
    if (bus.gnt !== 1'b0)      begin n_fail++; $display("FAIL reset_gnt: got %b, required 0", bus.gnt); end
    if (bus.rdata !== 8'h00)   begin n_fail++; $display("FAIL reset_rdata: got %h, required 00", bus.rdata); end
    if (bus.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.mem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req: got %b, required 0", bus.mem_req); end
    if (bus.mem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", bus.mem_we); end
    if (bus.mem_addr !== '0)   begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 000", bus.mem_addr); end
    if (bus.mem_wdata !== '0)  begin n_fail++; $display("FAIL reset_mem_wdata: got %h, required 00", bus.mem_wdata); end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d, required 0/0", hit_count, miss_count);
    end
`endif
    @(posedge clk); #2;
  endtask

  task automatic test_cold_load();
    int r0;
    fixed_delay = 3;
    backing[12'h0A5] = 8'h3C; ref_mem[12'h0A5] = 8'h3C;
    r0 = reads_seen;
    do_req(0, 12'h0A5, 8'h00);
    n_checks++;
    if (reads_seen - r0 != 1 || bus.rdata !== 8'h3C) begin
      n_fail++; $display("FAIL cold_load: got %0d reads rdata %h, required 1 read rdata 3c", reads_seen - r0, bus.rdata);
    end
  endtask

  task automatic test_load_hit();
    int m0;
    m0 = memreq_cycles;
    do_req(0, 12'h0A5, 8'h00);
    n_checks++;
    if (memreq_cycles != m0) begin
      n_fail++; $display("FAIL load_hit_memreq: got %0d mem_req cycles, required 0", memreq_cycles - m0);
    end
  endtask

  task automatic test_store_hit();
    int w0;
    w0 = writes_seen;
    do_req(1, 12'h0A5, 8'h77);
    do_req(0, 12'h0A5, 8'h00);
    wait_wb_empty();
    n_checks++;
    if (writes_seen - w0 != 1) begin
      n_fail++; $display("FAIL store_hit_write: got %0d writes, required 1", writes_seen - w0);
    end
  endtask

  task automatic test_store_miss_full();
    int w0;
    w0 = writes_seen;
    do_req(1, 12'h0A5, 8'h5A);
    do_req(1, 12'h1B3, 8'h11);
    do_req(0, 12'h1B3, 8'h00);
    n_checks++;
    if (writes_seen - w0 != 2) begin
      n_fail++; $display("FAIL store_miss_writes: got %0d writes, required 2", writes_seen - w0);
    end
  endtask

  task automatic test_conflict();
    fixed_delay = -1;
    do_req(0, 12'h005, 8'h00);
    do_req(0, 12'h105, 8'h00);
    do_req(0, 12'h005, 8'h00);
  endtask

  // A request while busy must be ignored: no hit, no write, no extra completion.
  task automatic test_ignore_busy();
    bit got = 0;
    int waitc = 0;
    wait_wb_empty();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h3E7;
    exp_rq.push_back(12'h3E7); exp_misses++;
    @(posedge clk); #2;
    bus.req_we = 1'b1; bus.req_wdata = 8'hEE;
    @(negedge clk);
    n_checks++;
    if (bus.hit !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL ignore_busy: got hit=%b busy=%b, required hit=0 busy=1", bus.hit, bus.busy);
    end
    @(posedge clk); #2;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    while (!got && waitc < 100) begin
      @(negedge clk);
      if (bus.gnt === 1'b1) got = 1; else waitc++;
    end
    @(posedge clk); #2;
    m_valid[7] = 1; m_tag[7] = 8'h3E;
    n_checks++;
    if (!got || bus.rdata !== ref_mem[12'h3E7]) begin
      n_fail++; $display("FAIL ignore_busy_load: got gnt=%0d rdata=%h, required gnt=1 rdata=%h", got, bus.rdata, ref_mem[12'h3E7]);
    end
    $display("txn LD addr=3e7 with ignored ST during miss rdata=%h", bus.rdata);
  endtask

  task automatic test_reset_mid();
    bit saw_gnt = 0;
    wait_wb_empty();
    hold = 1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h2C4;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h2C4) begin
      n_fail++; $display("FAIL reset_mid_pending: got req=%b addr=%h, required 1/2c4", bus.mem_req, bus.mem_addr);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_drop: got req=%b busy=%b, required 0/0", bus.mem_req, bus.busy);
    end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_stats: got %0d/%0d, required 0/0", hit_count, miss_count);
    end
`endif
    repeat (5) begin
      @(negedge clk);
      if (bus.gnt === 1'b1) saw_gnt = 1;
    end
    n_checks++;
    if (saw_gnt) begin n_fail++; $display("FAIL reset_mid_gnt: got gnt, required none"); end
    @(posedge clk); #2;
    clear_model();
    hold = 0;
    do_req(0, 12'h2C4, 8'h00);
  endtask

  task automatic test_random();
    logic [11:0] a;
    fixed_delay = -1;
    for (int n = 0; n < 150; n++) begin
      a = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), a, 8'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    wait_wb_empty();
    n_checks++;
    if (exp_wq.size() != 0 || exp_rq.size() != 0) begin
      n_fail++; $display("FAIL random_drain: got %0d/%0d pending, required 0/0", exp_wq.size(), exp_rq.size());
    end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
      n_fail++; $display("FAIL stats: got %0d/%0d, required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = 8'($urandom);
      backing[i] = v;
      ref_mem[i] = v;
    end
    clear_model();
    test_reset();
    test_cold_load();
    test_load_hit();
    test_store_hit();
    test_store_miss_full();
    test_conflict();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
